// File: rtl/synapse_driver.sv
// Spike-to-current synapse: edge-detected events with refractory gating, exponential decay, saturating Q9.7 current.
// Optional rate estimator compiled in with `define SYNAPSE_RATE_EN.
module synapse_driver #(
    parameter logic signed [15:0] WEIGHT      = 16'sd640,
    parameter int unsigned        TAU_SHIFT   = 3,
    parameter int unsigned        REFRACT     = 2,
    parameter int unsigned        WINDOW_LOG2 = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               spike_in,
    output logic signed [15:0] current,
    output logic               event_out,
    output logic [7:0]         rate,
    output logic               rate_valid
);

    localparam int unsigned CW = (REFRACT > 1) ? $clog2(REFRACT + 1) : 1;

    if (WINDOW_LOG2 == 0) begin : g_bad_window
        $error("WINDOW_LOG2 must be at least 1");
    end

    typedef enum logic {IDLE, REFR} state_t;

    state_t             state, state_next;
    logic [CW-1:0]      refr_cnt, refr_next;
    logic               spike_q;
    logic               rise;
    logic               accept;
    logic signed [15:0] decay;
    logic signed [16:0] sum;
    logic signed [15:0] current_next;

    always_comb begin
        rise       = spike_in & ~spike_q;
        accept     = rise && (state == IDLE);
        state_next = state;
        refr_next  = refr_cnt;
        case (state)
            IDLE: begin
                if (accept && (REFRACT != 0)) begin
                    state_next = REFR;
                    refr_next  = CW'(REFRACT);
                end
            end
            REFR: begin
                refr_next = refr_cnt - 1'b1;
                if (refr_cnt <= CW'(1)) begin
                    state_next = IDLE;
                    refr_next  = '0;
                end
            end
            default: begin
                state_next = IDLE;
                refr_next  = '0;
            end
        endcase
    end

    // Positive residue below 2^TAU_SHIFT still decays by 1 so the current always reaches exactly zero.
    always_comb begin
        decay = current >>> TAU_SHIFT;
        if (decay == '0 && current > 16'sd0) begin
            decay = 16'sd1;
        end
        sum = {current[15], current} - {decay[15], decay}
            + (accept ? {WEIGHT[15], WEIGHT} : 17'sd0);
        if (sum > 17'sd32767) begin
            current_next = 16'sh7FFF;
        end else if (sum < -17'sd32768) begin
            current_next = 16'sh8000;
        end else begin
            current_next = sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spike_q   <= 1'b0;
            state     <= IDLE;
            refr_cnt  <= '0;
            current   <= '0;
            event_out <= 1'b0;
        end else begin
            spike_q   <= spike_in;
            state     <= state_next;
            refr_cnt  <= refr_next;
            current   <= current_next;
            event_out <= accept;
        end
    end

`ifdef SYNAPSE_RATE_EN
    logic [WINDOW_LOG2-1:0] win_cnt;
    logic [7:0]             acc;
    logic [7:0]             acc_inc;

    always_comb begin
        acc_inc = acc;
        if (accept && (acc != 8'hFF)) begin
            acc_inc = acc + 1'b1;
        end
    end

    // The wrap cycle's own event is folded into the published rate, not the next window.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt    <= '0;
            acc        <= '0;
            rate       <= '0;
            rate_valid <= 1'b0;
        end else begin
            win_cnt <= win_cnt + 1'b1;
            if (&win_cnt) begin
                rate       <= acc_inc;
                acc        <= '0;
                rate_valid <= 1'b1;
            end else begin
                acc        <= acc_inc;
                rate_valid <= 1'b0;
            end
        end
    end
`else
    assign rate       = '0;
    assign rate_valid = 1'b0;
`endif

endmodule

// File: tb/tb_synapse_driver.sv
// Self-checking bench for synapse_driver: three parameterisations checked against a cycle-level arithmetic model.
module tb_synapse_driver;

    logic               clk;
    logic               reset;
    logic               sp_a, sp_b, sp_c;
    logic signed [15:0] cur_a, cur_b, cur_c;
    logic               ev_a, ev_b, ev_c;
    logic [7:0]         rate_a, rate_b, rate_c;
    logic               rv_a, rv_b, rv_c;

    int n_checks = 0;
    int n_fail   = 0;

    synapse_driver #(.WEIGHT(16'sd640), .TAU_SHIFT(3), .REFRACT(2), .WINDOW_LOG2(4)) u_a (
        .clk(clk), .reset(reset), .spike_in(sp_a), .current(cur_a),
        .event_out(ev_a), .rate(rate_a), .rate_valid(rv_a));

    synapse_driver #(.WEIGHT(16'sd32000), .TAU_SHIFT(8), .REFRACT(0)) u_b (
        .clk(clk), .reset(reset), .spike_in(sp_b), .current(cur_b),
        .event_out(ev_b), .rate(rate_b), .rate_valid(rv_b));

    synapse_driver #(.WEIGHT(-16'sd640), .TAU_SHIFT(3), .REFRACT(2), .WINDOW_LOG2(3)) u_c (
        .clk(clk), .reset(reset), .spike_in(sp_c), .current(cur_c),
        .event_out(ev_c), .rate(rate_c), .rate_valid(rv_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: refractory expressed as "cycles since last accepted event".
    typedef struct {
        int cur;
        bit prev;
        int since;
        int acc;
        int rate;
        bit rv;
        bit ev;
        int cyc;
    } mst_t;

    mst_t ma, mb, mc;

    function automatic mst_t mstep(mst_t m, bit rst, bit spk, int w, int tau, int refr, int wlog);
        mst_t n;
        int   d;
        int   p2;
        int   nxt;
        int   win;
        bit   acc_ev;
        n = m;
        if (rst) begin
            n.cur = 0; n.prev = 0; n.since = 1000; n.acc = 0;
            n.rate = 0; n.rv = 0; n.ev = 0; n.cyc = 0;
            return n;
        end
        acc_ev = spk && !m.prev && (m.since > refr);
        p2 = 1 << tau;
        if (m.cur >= 0) d = m.cur / p2;
        else            d = -((-m.cur + p2 - 1) / p2);
        if (d == 0 && m.cur > 0) d = 1;
        nxt = m.cur - d + (acc_ev ? w : 0);
        if (nxt > 32767)  nxt = 32767;
        if (nxt < -32768) nxt = -32768;
        n.cur   = nxt;
        n.ev    = acc_ev;
        n.prev  = spk;
        n.since = acc_ev ? 1 : ((m.since < 1000) ? m.since + 1 : 1000);
        win = 1 << wlog;
        if ((m.cyc % win) == win - 1) begin
            n.rate = (m.acc + acc_ev > 255) ? 255 : m.acc + acc_ev;
            n.acc  = 0;
            n.rv   = 1;
        end else begin
            n.acc = (m.acc + acc_ev > 255) ? 255 : m.acc + acc_ev;
            n.rv  = 0;
        end
        n.cyc = m.cyc + 1;
        return n;
    endfunction

    function automatic int exp_rate(mst_t m);
`ifdef SYNAPSE_RATE_EN
        return m.rate;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_rv(mst_t m);
`ifdef SYNAPSE_RATE_EN
        return int'(m.rv);
`else
        return 0;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    int ev_cnt_a;
    int peak_a;
    int rv_cnt_a;
    int min_b;
    int sat_b;

    task automatic cyc(input bit rst, input bit a, input bit b, input bit c);
        reset = rst;
        sp_a  = a;
        sp_b  = b;
        sp_c  = c;
        ma = mstep(ma, rst, a, 640, 3, 2, 4);
        mb = mstep(mb, rst, b, 32000, 8, 0, 8);
        mc = mstep(mc, rst, c, -640, 3, 2, 3);
        @(posedge clk);
        #1;
        check("a_current", cur_a, ma.cur);
        check("a_event", ev_a, ma.ev);
        check("a_rate", rate_a, exp_rate(ma));
        check("a_rate_valid", rv_a, exp_rv(ma));
        check("b_current", cur_b, mb.cur);
        check("b_event", ev_b, mb.ev);
        check("b_rate", rate_b, exp_rate(mb));
        check("b_rate_valid", rv_b, exp_rv(mb));
        check("c_current", cur_c, mc.cur);
        check("c_event", ev_c, mc.ev);
        check("c_rate", rate_c, exp_rate(mc));
        check("c_rate_valid", rv_c, exp_rv(mc));
        if (ev_a) ev_cnt_a++;
        if (cur_a == 16'sd640) peak_a++;
        if (rv_a) rv_cnt_a++;
        if (int'(cur_b) < min_b) min_b = cur_b;
        if (cur_b == 16'sh7FFF) sat_b = 1;
    endtask

    typedef struct {
        bit rst;
        bit spk;
        int cur;
        bit ev;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit sa, sb, sc, rr;

        reset = 1'b1; sp_a = 1'b0; sp_b = 1'b0; sp_c = 1'b0;
        ev_cnt_a = 0; peak_a = 0; rv_cnt_a = 0; min_b = 0; sat_b = 0;

        // Single spike on the default-weight synapse: known decay trajectory.
        vecs[0] = '{1'b1, 1'b0, 0,   1'b0};
        vecs[1] = '{1'b1, 1'b0, 0,   1'b0};
        vecs[2] = '{1'b0, 1'b1, 640, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 560, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 490, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 429, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 376, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 329, 1'b0};
        for (int i = 0; i < 8; i++) begin
            cyc(vecs[i].rst, vecs[i].spk, 1'b0, 1'b0);
            check("tbl_current", cur_a, vecs[i].cur);
            check("tbl_event", ev_a, vecs[i].ev);
        end
        for (int i = 0; i < 80; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("decay_to_zero", cur_a, 0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("zero_holds", cur_a, 0);

        // Level held for 10 cycles gives one event and one peak.
        ev_cnt_a = 0; peak_a = 0;
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("held_one_event", ev_cnt_a, 1);
        check("held_one_peak", peak_a, 1);

        // Refractory: edge at k+2 dropped; edge at k+3 accepted.
        for (int i = 0; i < 100; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        ev_cnt_a = 0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("refr_drop_k2", ev_cnt_a, 1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        ev_cnt_a = 0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("refr_accept_k3", ev_cnt_a, 2);

        // Saturation on the large excitatory weight; inhibitory single spike.
        min_b = 0; sat_b = 0;
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, (i % 2) == 0, i == 0);
        check("b_clamped_seen", sat_b, 1);
        check("b_never_negative", int'(min_b >= 0), 1);
        for (int i = 0; i < 100; i++) cyc(1'b0, 1'b0, 1'b0, i == 0);
        check("c_decay_zero", cur_c, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        check("c_inhibit", cur_c, -640);
        for (int i = 0; i < 80; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("c_inhibit_zero", cur_c, 0);

        // Rate window: three events in the first 16 cycles, last one on the wrap cycle.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        rv_cnt_a = 0;
        for (int j = 0; j < 16; j++) cyc(1'b0, (j == 0) || (j == 5) || (j == 15), 1'b0, 1'b0);
`ifdef SYNAPSE_RATE_EN
        check("rate_window", rate_a, 3);
        check("rate_valid_wrap", rv_a, 1);
`else
        check("rate_window", rate_a, 0);
        check("rate_valid_wrap", rv_a, 0);
`endif
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SYNAPSE_RATE_EN
        check("rate_valid_pulses", rv_cnt_a, 1);
`else
        check("rate_valid_pulses", rv_cnt_a, 0);
`endif

        // Reset inside refractory with a coincident edge, then release.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        check("rst_prio_current", cur_a, 0);
        check("rst_prio_event", ev_a, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("held_across_release", ev_a, 1);
        check("held_across_cur", cur_a, 640);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        check("edge_after_release", ev_a, 1);
        check("edge_after_cur", cur_a, 640);

        // Randomized traffic with sparse resets.
        for (int i = 0; i < 600; i++) begin
            rr = ($urandom_range(99) == 0);
            sa = ($urandom_range(2) == 0);
            sb = ($urandom_range(2) == 0);
            sc = ($urandom_range(2) == 0);
            cyc(rr, sa, sb, sc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
